// File: rtl/sd_host_pkg.sv
// Shared types and helpers for the sd_host register-set port and its initiator.
// Holds the access-size encoding, master FSM states and the byte-lane steering functions.
package sd_host_pkg;

    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        REQ_BYTE = 2'b01,
        REQ_HALF = 2'b10,
        REQ_WORD = 2'b11
    } req_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } master_state_t;

    // Accesses must be naturally aligned; REQ_NONE is never a legal command size.
    function automatic logic size_addr_ok(input req_size_t size, input logic [1:0] lane);
        case (size)
            REQ_BYTE: return 1'b1;
            REQ_HALF: return ~lane[0];
            REQ_WORD: return (lane == 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [REG_DATA_W-1:0] lane_replicate(input req_size_t size,
                                                             input logic [REG_DATA_W-1:0] wdata);
        case (size)
            REQ_BYTE: return {4{wdata[7:0]}};
            REQ_HALF: return {2{wdata[15:0]}};
            default:  return wdata;
        endcase
    endfunction

    function automatic logic [REG_DATA_W-1:0] lane_extract(input req_size_t size,
                                                           input logic [1:0] lane,
                                                           input logic [REG_DATA_W-1:0] data);
        logic [REG_DATA_W-1:0] shifted;
        shifted = '0;
        case (size)
            REQ_BYTE: begin
                shifted = data >> {lane, 3'b000};
                return {24'b0, shifted[7:0]};
            end
            REQ_HALF: begin
                shifted = data >> {lane[1], 4'b0000};
                return {16'b0, shifted[15:0]};
            end
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/sd_reg_master.sv
// Register-port initiator: one command in, one held bus access, one response out.
// Illegal commands answer with an error without touching the bus; a silent target times out.
module sd_reg_master
    import sd_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wnr,
    input  logic [1:0]            cmd_size,
    input  logic [REG_ADDR_W-1:0] cmd_addr,
    input  logic [REG_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REG_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  wnr,
    output logic [1:0]            req,
    output logic [REG_ADDR_W-1:0] address,
    output logic [REG_DATA_W-1:0] data_out,
    input  logic                  ack,
    input  logic [REG_DATA_W-1:0] data_in,
    output master_state_t         dbg_state
);

    // Handshakes: a command transfers on a rising edge with cmd_valid & cmd_ready, a response
    // on a rising edge with rsp_valid & rsp_ready; rsp_* stay stable while rsp_valid waits.

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    master_state_t state;
    req_size_t     req_q;
    req_size_t     size_in;
    logic [15:0]   tmo_cnt;

    assign size_in   = req_size_t'(cmd_size);
    assign req       = req_q;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_q     <= REQ_NONE;
            wnr       <= 1'b0;
            address   <= '0;
            data_out  <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (size_addr_ok(size_in, cmd_addr[1:0])) begin
                            state    <= ST_BUS;
                            req_q    <= size_in;
                            wnr      <= cmd_wnr;
                            address  <= cmd_addr;
                            data_out <= lane_replicate(size_in, cmd_wdata);
                            tmo_cnt  <= '0;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack is checked before the limit so a completion on the last cycle still succeeds.
                    if (ack) begin
                        state     <= ST_RESP;
                        req_q     <= REQ_NONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wnr ? '0 : lane_extract(req_q, address[1:0], data_in);
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= ST_RESP;
                        req_q     <= REQ_NONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    req_q     <= REQ_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_reg_master.sv
// Bench for sd_reg_master: scenario tasks drive commands and play the sd_host responder,
// while a response monitor pops expected {err, rdata} values from a queue.
module tb_sd_reg_master;
    import sd_host_pkg::*;

    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wnr = 1'b0;
    logic [1:0]    cmd_size = 2'b00;
    logic [7:0]    cmd_addr = 8'h00;
    logic [31:0]   cmd_wdata = 32'h0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          wnr;
    logic [1:0]    req;
    logic [7:0]    address;
    logic [31:0]   data_out;
    logic          ack = 1'b0;
    logic [31:0]   data_in = 32'h0;
    master_state_t dbg_state;

    logic [32:0] exp_q[$];
    logic [32:0] sb_exp;
    int checks = 0;
    int errors = 0;

    logic [1:0] bad_size [5] = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b00};
    logic [7:0] bad_addr [5] = '{8'h02, 8'h00, 8'h05, 8'h01, 8'h13};

    always #5 clk = ~clk;

    sd_reg_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wnr   (cmd_wnr),
        .cmd_size  (cmd_size),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wnr       (wnr),
        .req       (req),
        .address   (address),
        .data_out  (data_out),
        .ack       (ack),
        .data_in   (data_in),
        .dbg_state (dbg_state)
    );

    // Scoreboard: a response is compared on the cycle it will be consumed.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got err=%0b rdata=%h, none expected", rsp_err, rsp_rdata);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== sb_exp) begin
                    errors++;
                    $display("FAIL rsp_compare got err=%0b rdata=%h exp err=%0b rdata=%h",
                             rsp_err, rsp_rdata, sb_exp[32], sb_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_read(input logic [1:0] s, input logic [7:0] a,
                                               input logic [31:0] d);
        case (s)
            2'b01: begin
                case (a[1:0])
                    2'd0: return {24'h0, d[7:0]};
                    2'd1: return {24'h0, d[15:8]};
                    2'd2: return {24'h0, d[23:16]};
                    default: return {24'h0, d[31:24]};
                endcase
            end
            2'b10: return a[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_write(input logic [1:0] s, input logic [31:0] w);
        case (s)
            2'b01: return {w[7:0], w[7:0], w[7:0], w[7:0]};
            2'b10: return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [1:0] s, input logic [7:0] a,
                             input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_wnr   = w;
        cmd_size  = s;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_handshake got ready=%0b valid=%0b state=%0d exp 1 0 0",
                     cmd_ready, rsp_valid, dbg_state);
        end
        checks++;
        if (req !== 2'b00 || wnr !== 1'b0 || address !== 8'h00 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got req=%b wnr=%0b addr=%h data=%h exp all zero",
                     req, wnr, address, data_out);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp got rdata=%h err=%0b exp 0 0", rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_word_read();
        rsp_ready = 1'b1;
        data_in = 32'hDEADBEEF;
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        drive_cmd(1'b0, 2'b11, 8'h24, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req !== 2'b11 || address !== 8'h24 || wnr !== 1'b0) begin
                errors++;
                $display("FAIL word_read_bus cycle %0d got req=%b addr=%h wnr=%0b exp 11 24 0",
                         i, req, address, wnr);
            end
            if (i == 2) ack = 1'b1;
            step();
        end
        ack = 1'b0;
        checks++;
        if (req !== 2'b00 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL word_read_done got req=%b valid=%0b exp 00 1", req, rsp_valid);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL word_read_idle got ready=%0b valid=%0b exp 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_byte_write();
        data_in = 32'h5A5A0F0F;
        exp_q.push_back({1'b0, 32'h0});
        drive_cmd(1'b1, 2'b01, 8'h07, 32'h000000A5);
        checks++;
        if (req !== 2'b01 || address !== 8'h07 || data_out !== 32'hA5A5A5A5 || wnr !== 1'b1) begin
            errors++;
            $display("FAIL byte_write_bus got req=%b addr=%h data=%h wnr=%0b exp 01 07 a5a5a5a5 1",
                     req, address, data_out, wnr);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL min_latency got valid=%0b exp 1", rsp_valid);
        end
        step();
    endtask

    task automatic test_half_read();
        data_in = 32'h1234ABCD;
        exp_q.push_back({1'b0, 32'h00001234});
        drive_cmd(1'b0, 2'b10, 8'h12, 32'h0);
        checks++;
        if (req !== 2'b10 || address !== 8'h12) begin
            errors++;
            $display("FAIL half_read_bus got req=%b addr=%h exp 10 12", req, address);
        end
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 5; k++) begin
            rsp_ready = 1'b0;
            exp_q.push_back({1'b1, 32'h0});
            drive_cmd(k[0], bad_size[k], bad_addr[k], $urandom);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || req !== 2'b00 || dbg_state !== ST_RESP) begin
                errors++;
                $display("FAIL illegal_%0d got valid=%0b err=%0b req=%b state=%0d exp 1 1 00 2",
                         k, rsp_valid, rsp_err, req, dbg_state);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || req !== 2'b00) begin
                errors++;
                $display("FAIL illegal_hold_%0d got valid=%0b err=%0b rdata=%h req=%b exp 1 1 0 00",
                         k, rsp_valid, rsp_err, rsp_rdata, req);
            end
            rsp_ready = 1'b1;
            step();
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal_ready_%0d got %0b exp 1", k, cmd_ready);
            end
        end
    endtask

    task automatic test_timeout();
        rsp_ready = 1'b0;
        data_in = 32'hFFFFFFFF;
        exp_q.push_back({1'b1, 32'h0});
        drive_cmd(1'b0, 2'b11, 8'h40, 32'h0);
        for (int i = 0; i < TMO; i++) begin
            checks++;
            if (req !== 2'b11) begin
                errors++;
                $display("FAIL timeout_req cycle %0d got %b exp 11", i, req);
            end
            step();
        end
        checks++;
        if (req !== 2'b00 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_abort got req=%b valid=%0b err=%0b rdata=%h exp 00 1 1 0",
                     req, rsp_valid, rsp_err, rsp_rdata);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || dbg_state !== ST_RESP) begin
            errors++;
            $display("FAIL late_ack got valid=%0b err=%0b rdata=%h state=%0d exp 1 1 0 2",
                     rsp_valid, rsp_err, rsp_rdata, dbg_state);
        end
        rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_ack_at_limit();
        rsp_ready = 1'b1;
        data_in = 32'hC0FFEE11;
        exp_q.push_back({1'b0, 32'hC0FFEE11});
        drive_cmd(1'b0, 2'b11, 8'h44, 32'h0);
        for (int i = 0; i < TMO; i++) begin
            if (i == TMO - 1) ack = 1'b1;
            step();
        end
        ack = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_limit got valid=%0b err=%0b exp 1 0", rsp_valid, rsp_err);
        end
        step();
    endtask

    task automatic test_stray_ack();
        ack = 1'b1;
        step();
        step();
        ack = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || req !== 2'b00) begin
            errors++;
            $display("FAIL stray_ack got state=%0d valid=%0b ready=%0b req=%b exp 0 0 1 00",
                     dbg_state, rsp_valid, cmd_ready, req);
        end
    endtask

    task automatic test_reset_mid_bus();
        drive_cmd(1'b0, 2'b11, 8'h08, 32'h0);
        checks++;
        if (req !== 2'b11) begin
            errors++;
            $display("FAIL rst_bus_start got req=%b exp 11", req);
        end
        reset = 1'b1;
        step();
        checks++;
        if (req !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_bus_drop got req=%b valid=%0b exp 00 0", req, rsp_valid);
        end
        reset = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_bus_release got ready=%0b valid=%0b exp 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic       w;
        logic [1:0] s;
        logic [7:0] a;
        logic [31:0] wd;
        logic [31:0] bd;
        int         budget;
        for (int n = 0; n < 12; n++) begin
            w  = 1'($urandom_range(0, 1));
            s  = 2'($urandom_range(1, 3));
            a  = 8'($urandom_range(0, 255));
            if (s == 2'b10) a[0] = 1'b0;
            if (s == 2'b11) a[1:0] = 2'b00;
            wd = $urandom;
            bd = $urandom;
            data_in = bd;
            exp_q.push_back({1'b0, w ? 32'h0 : model_read(s, a, bd)});
            drive_cmd(w, s, a, wd);
            checks++;
            if (req !== s || address !== a || wnr !== w || (w && data_out !== model_write(s, wd))) begin
                errors++;
                $display("FAIL b2b_bus_%0d got req=%b addr=%h wnr=%0b data=%h exp %b %h %0b %h",
                         n, req, address, wnr, data_out, s, a, w, model_write(s, wd));
            end
            repeat ($urandom_range(0, 3)) step();
            ack = 1'b1;
            step();
            ack = 1'b0;
            budget = 20;
            while (cmd_ready !== 1'b1 && budget > 0) begin
                rsp_ready = (budget < 15) ? 1'b1 : 1'($urandom_range(0, 1));
                step();
                budget--;
            end
            rsp_ready = 1'b1;
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_wait_%0d got ready=%0b exp 1 within budget", n, cmd_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_half_read();
        test_illegal();
        test_timeout();
        test_ack_at_limit();
        test_stray_ack();
        test_reset_mid_bus();
        test_back_to_back();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
